if_stage: RTL and testbench

- Instruction-fetch stage of the RV32I core.
- Owns the PC and issues in-order requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents {instr, pc, pcplus4} to decode with a valid/ready handshake.
- Decode slices id_instr[31:7] and feeds it to the immediate extender. A redirect from execute flushes everything in flight.

---
 rtl/if_pkg.sv | 9 +
 rtl/if_fifo.sv | 49 ++++
 rtl/if_stage.sv | 100 ++++++++++
 tb/tb_if_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared word/entry types and the default reset PC for the fetch stage.
package if_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef logic [31:0] word_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_entry_t;
endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous FIFO of fetch entries; flush outranks push and pop.
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  if_entry_t               din,
  input  logic                    pop,
  input  logic                    flush,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output if_entry_t               head
);
  localparam int AW = $clog2(DEPTH);
  if_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    count = cnt_q;
    head = mem_q[rd_q];
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  // storage needs no reset: nothing is read before it is written
  always_ff @(posedge clk)
    if (do_push && !flush) mem_q[wr_q] <= din;
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !flush))
    else $error("if_fifo overflow");
endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I instruction fetch with in-order imem requests, a small decode FIFO and redirect flush.
// Optional IF_PERF_CNT_EN adds saturating stall/flush counters.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          DEPTH     = 2,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pcplus4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] if_stall_cnt,
  output logic [31:0] if_flush_cnt
`endif
);
  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam int FW = $clog2(DEPTH) + 1;
  logic started_q, started_d;
  logic [31:0] pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d;
  logic accept, keep;
  if_entry_t aq_din, aq_head, iq_din, iq_head;
  logic aq_full, aq_empty, iq_full, iq_empty;
  logic [FW-1:0] aq_count, iq_count;
  logic unused_ok;
  always_comb begin
    imem_req_addr = {pc_q[31:2], 2'b00};
    imem_req_valid = started_q && !redirect_valid
                     && (32'(out_q) + 32'(iq_count) < 32'(DEPTH))
                     && (32'(out_q) < 32'(MAX_OUTST));
    accept = imem_req_valid && imem_req_ready;
    keep = imem_rsp_valid && drop_q == '0;
    aq_din = '{instr: '0, pc: imem_req_addr};
    iq_din = '{instr: imem_rsp_data, pc: aq_head.pc};
    id_valid = !iq_empty;
    id_instr = id_valid ? iq_head.instr : '0;
    id_pc = id_valid ? iq_head.pc : '0;
    id_pcplus4 = id_valid ? iq_head.pc + 32'd4 : '0;
    started_d = 1'b1;
    pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : accept ? pc_q + 32'd4 : pc_q;
    out_d = out_q + CW'(accept) - CW'(imem_rsp_valid);
    // every request still in flight at a redirect is stale, except one returning right now
    drop_d = redirect_valid ? out_q - CW'(imem_rsp_valid)
           : (imem_rsp_valid && drop_q != '0) ? drop_q - CW'(1) : drop_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      started_q <= 1'b0;
      pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      started_q <= started_d;
      pc_q <= pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  if_fifo #(.DEPTH(DEPTH)) u_addr_q (
    .clk(clk), .rst_n(rst_n), .push(accept), .din(aq_din), .pop(keep),
    .flush(redirect_valid), .full(aq_full), .empty(aq_empty), .count(aq_count), .head(aq_head)
  );
  if_fifo #(.DEPTH(DEPTH)) u_instr_q (
    .clk(clk), .rst_n(rst_n), .push(keep), .din(iq_din), .pop(id_valid && id_ready),
    .flush(redirect_valid), .full(iq_full), .empty(iq_empty), .count(iq_count), .head(iq_head)
  );
  assign unused_ok = ^{aq_full, aq_count, aq_head.instr, iq_full, redirect_pc[1:0]};
  assert property (@(posedge clk) disable iff (!rst_n) keep |-> !aq_empty)
    else $error("if_stage response without a matching request");
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_q, stall_d, flush_q, flush_d;
  always_comb begin
    stall_d = (id_ready && !id_valid && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    flush_d = (redirect_valid && flush_q != '1) ? flush_q + 32'd1 : flush_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  assign if_stall_cnt = stall_q;
  assign if_flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized bench for if_stage; expected fetch order comes from a sequential program-counter model.
module tb_if_stage;
  localparam int DEPTH = 2;
  localparam int MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid;
  logic id_valid, id_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, id_instr, id_pc, id_pcplus4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] if_stall_cnt, if_flush_cnt;
  int unsigned stall_m, flush_m;
`endif
  always #5 clk = ~clk;
  if_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_pcplus4(id_pcplus4)
`ifdef IF_PERF_CNT_EN
    , .if_stall_cnt(if_stall_cnt), .if_flush_cnt(if_flush_cnt)
`endif
  );
  typedef struct { int unsigned rdy; logic [31:0] data; } rsp_t;
  rsp_t pend[$];
  logic [31:0] exp_id_q[$];
  logic [31:0] exp_req_q[$];
  logic [31:0] next_id, next_req, force_pc;
  logic force_redir;
  int unsigned cyc, last_rdy;
  int checks, errors;
  int p_ready, p_id, p_redir, lat_min, lat_max;
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction
  function automatic logic [31:0] rand_target();
    int unsigned sel;
    sel = $urandom_range(2);
    if (sel == 0) return $urandom;
    if (sel == 1) return 32'hFFFF_FFF0 | ($urandom & 32'hF);
    return $urandom & 32'h3FF;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic refill();
    while (exp_id_q.size() < 8) begin exp_id_q.push_back(next_id); next_id += 32'd4; end
    while (exp_req_q.size() < 8) begin exp_req_q.push_back(next_req); next_req += 32'd4; end
  endtask
  task automatic restart_at(logic [31:0] pc);
    exp_id_q.delete();
    exp_req_q.delete();
    next_id = {pc[31:2], 2'b00};
    next_req = {pc[31:2], 2'b00};
  endtask
  task automatic cycle();
    int unsigned r;
    @(posedge clk);
    cyc++;
    #1;
    imem_req_ready = $urandom_range(99) < p_ready;
    id_ready = $urandom_range(99) < p_id;
    redirect_valid = 1'b0;
    if (force_redir || (p_redir > 0 && $urandom_range(99) < p_redir)) begin
      redirect_valid = 1'b1;
      redirect_pc = force_redir ? force_pc : rand_target();
      force_redir = 1'b0;
      restart_at(redirect_pc);
    end
    if (pend.size() > 0 && pend[0].rdy <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = pend[0].data;
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
    end
    refill();
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      r = cyc + $urandom_range(lat_max, lat_min);
      if (r <= last_rdy) r = last_rdy + 1;
      last_rdy = r;
      pend.push_back('{rdy: r, data: mem_word(imem_req_addr)});
    end
    checks++;
    if (pend.size() > MAX_OUTST) begin
      errors++;
      $display("FAIL outstanding: %0d in flight, limit %0d", pend.size(), MAX_OUTST);
    end
`ifdef IF_PERF_CNT_EN
    chk("stall_cnt", if_stall_cnt, stall_m);
    chk("flush_cnt", if_flush_cnt, flush_m);
    if (id_ready && !id_valid) stall_m++;
    if (redirect_valid) flush_m++;
`endif
  endtask
  task automatic do_reset(int hold);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_pcplus4", id_pcplus4, 0);
    pend.delete();
    last_rdy = cyc;
    restart_at(RESET_PC);
`ifdef IF_PERF_CNT_EN
    stall_m = 0;
    flush_m = 0;
`endif
    repeat (hold) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask
  // monitor: compares every accepted request and every consumed instruction with the model queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) begin
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_addr: got %h expected none", imem_req_addr);
        end else chk("req_addr", imem_req_addr, exp_req_q.pop_front());
      end
      if (id_valid && id_ready && !redirect_valid) begin
        if (exp_id_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL id_pc: got %h expected none", id_pc);
        end else begin
          logic [31:0] e;
          e = exp_id_q.pop_front();
          chk("id_pc", id_pc, e);
          chk("id_instr", id_instr, mem_word(e));
          chk("id_pcplus4", id_pcplus4, e + 32'd4);
        end
      end
    end
  end
  initial begin
    checks = 0; errors = 0; cyc = 0; last_rdy = 0;
    force_redir = 1'b0; force_pc = '0; redirect_pc = '0; imem_rsp_data = '0;
    p_ready = 100; p_id = 100; p_redir = 0; lat_min = 1; lat_max = 1;
    do_reset(2);
    cycle(); cycle();
    chk("first_valid_early", 32'(id_valid), 0);
    cycle();
    chk("first_valid", 32'(id_valid), 1);
    repeat (6) cycle();
    p_id = 0; lat_max = 3;
    repeat (10) cycle();
    chk("stall_req_valid", 32'(imem_req_valid), 0);
    chk("stall_id_valid", 32'(id_valid), 1);
    p_id = 100;
    repeat (10) cycle();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && pend.size() != 2; i++) cycle();
    chk("outst_before_redirect", pend.size(), 2);
    force_redir = 1'b1; force_pc = 32'h100;
    repeat (14) cycle();
    force_redir = 1'b1; force_pc = 32'h103;
    cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (imem_req_valid) break;
    end
    chk("redirect_req_valid", 32'(imem_req_valid), 1);
    chk("redirect_addr", imem_req_addr, 32'h100);
    repeat (10) cycle();
    lat_min = 1; lat_max = 2; p_id = 0;
    for (int i = 0; i < 20 && !id_valid; i++) cycle();
    chk("pre_flush_valid", 32'(id_valid), 1);
    p_id = 100; force_redir = 1'b1; force_pc = 32'h200;
    cycle();
    cycle();
    chk("flush_empty", 32'(id_valid), 0);
    repeat (10) cycle();
    force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
    repeat (15) cycle();
    do_reset(2);
    p_ready = 0;
    repeat (5) cycle();
    p_ready = 100;
    repeat (3) begin force_redir = 1'b1; force_pc = $urandom & 32'hFFC; cycle(); end
    repeat (12) cycle();
    for (int i = 0; i < 1500; i++) begin
      if (i % 500 == 250) do_reset(1 + $urandom_range(2));
      if (i % 100 == 0) begin
        p_ready = $urandom_range(100, 30);
        p_id = $urandom_range(100, 20);
        p_redir = $urandom_range(10);
        lat_min = $urandom_range(2, 1);
        lat_max = lat_min + $urandom_range(2);
      end
      cycle();
    end
    p_ready = 100; p_id = 100; p_redir = 0;
    repeat (20) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
